// File: rtl/spm_seq_ctrl.sv
// spm_seq_ctrl: sequences operands into a serial-parallel multiplier and deserializes its product; define SPM_BACKPRESSURE_EN to hold results until result_ready
module spm_seq_ctrl #(
  parameter int SIZE    = 32,
  parameter int SPM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product,
  input  logic              result_ready,
  output logic              spm_rst,
  output logic [SIZE-1:0]   spm_x,
  output logic              spm_y,
  input  logic              spm_p
);
  localparam int CW = $clog2(2*SIZE+SPM_LAT+1);
  localparam logic [CW-1:0] LAST = CW'(2*SIZE+SPM_LAT-1);
  localparam logic [CW-1:0] LAT  = CW'(SPM_LAT);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [SIZE-1:0]   x_q, y_q;
  logic [2*SIZE-1:0] prod_q;
  logic              leave_done;
`ifdef SPM_BACKPRESSURE_EN
  assign leave_done = result_ready;
`else
  logic unused_result_ready;
  assign unused_result_ready = result_ready;
  assign leave_done = 1'b1;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // next-state: RUN lasts until the last product bit has been captured
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (leave_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state; the SPM is held clear whenever it is not running
  always_comb begin
    busy    = state_q != IDLE;
    done    = state_q == DONE;
    spm_rst = state_q != RUN;
    spm_y   = (state_q == RUN) & y_q[0];
    spm_x   = x_q;
    product = prod_q;
  end
  // operand latch, y serializer, cycle counter and product deserializer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else if (state_q == IDLE && start) begin
      x_q    <= a;
      y_q    <= b;
      cnt_q  <= '0;
      prod_q <= '0;
    end else if (state_q == RUN) begin
      y_q   <= y_q >> 1;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q >= LAT) prod_q <= {spm_p, prod_q[2*SIZE-1:1]};
    end
endmodule

// File: tb/tb_spm_seq_ctrl.sv
// tb_spm_seq_ctrl: directed bench for spm_seq_ctrl driving a behavioural one-cycle-latency SPM
module tb_spm_seq_ctrl;
  localparam int SIZE = 32;
  logic              clk = 0, rst_n = 0, start = 0, result_ready = 1;
  logic [SIZE-1:0]   a = '0, b = '0;
  logic              busy, done, spm_rst, spm_y, spm_p;
  logic [2*SIZE-1:0] product;
  logic [SIZE-1:0]   spm_x;
  logic [SIZE-1:0]   acc;
  int checks = 0, errors = 0;

  spm_seq_ctrl #(.SIZE(SIZE), .SPM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .busy(busy), .done(done),
    .product(product), .result_ready(result_ready), .spm_rst(spm_rst), .spm_x(spm_x),
    .spm_y(spm_y), .spm_p(spm_p)
  );

  always #5 clk = ~clk;

  // serial-parallel multiplier: add x when y is set, emit LSB, keep carries; output registered
  always_ff @(posedge clk)
    if (spm_rst) {acc, spm_p} <= '0;
    else {acc, spm_p} <= {1'b0, acc} + {1'b0, (spm_y ? spm_x : {SIZE{1'b0}})};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                        output int lat, output logic [2*SIZE-1:0] ybits);
    a = av; b = bv; start = 1;
    tick();
    start = 0;
    lat = 0;
    ybits = '0;
    while (!done && lat < 200) begin
      if (lat < 2*SIZE) ybits[lat] = spm_y;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (product !== 64'h0) begin errors++; $display("FAIL reset_product got %h exp 0", product); end
    checks++; if (spm_x !== 32'h0) begin errors++; $display("FAIL reset_spm_x got %h exp 0", spm_x); end
    checks++; if (spm_y !== 1'b0) begin errors++; $display("FAIL reset_spm_y got %b exp 0", spm_y); end
    checks++; if (spm_rst !== 1'b1) begin errors++; $display("FAIL reset_spm_rst got %b exp 1", spm_rst); end
  endtask

  task automatic test_basic();
    int lat;
    logic [2*SIZE-1:0] yb;
    a = 3; b = 5; start = 1;
    tick();
    start = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    checks++; if (spm_rst !== 1'b0) begin errors++; $display("FAIL basic_spm_rst got %b exp 0", spm_rst); end
    checks++; if (spm_y !== 1'b1) begin errors++; $display("FAIL basic_first_y got %b exp 1", spm_y); end
    lat = 0;
    yb = '0;
    while (!done && lat < 200) begin
      if (lat < 2*SIZE) yb[lat] = spm_y;
      tick();
      lat++;
    end
    checks++; if (lat !== 65) begin errors++; $display("FAIL basic_latency got %0d exp 65", lat); end
    checks++; if (yb !== 64'h5) begin errors++; $display("FAIL basic_y_pattern got %h exp 5", yb); end
    checks++; if (product !== 64'h0F) begin errors++; $display("FAIL basic_product got %h exp f", product); end
    checks++; if (spm_rst !== 1'b1) begin errors++; $display("FAIL basic_done_spm_rst got %b exp 1", spm_rst); end
    result_ready = 1;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b exp 0", busy); end
    checks++; if (product !== 64'h0F) begin errors++; $display("FAIL basic_product_held got %h exp f", product); end
  endtask

  task automatic test_full_range();
    int lat;
    logic [2*SIZE-1:0] yb;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, yb);
    checks++; if (lat !== 65) begin errors++; $display("FAIL full_latency got %0d exp 65", lat); end
    checks++; if (product !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL full_product got %h exp fffffffe00000001", product); end
    checks++; if (yb !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL full_y_pattern got %h exp ffffffff", yb); end
    tick();
  endtask

  task automatic test_zero();
    int lat;
    logic [2*SIZE-1:0] yb;
    run_op(32'h1234_5678, 32'h0, lat, yb);
    checks++; if (lat !== 65) begin errors++; $display("FAIL zero_latency got %0d exp 65", lat); end
    checks++; if (product !== 64'h0) begin errors++; $display("FAIL zero_product got %h exp 0", product); end
    checks++; if (spm_x !== 32'h1234_5678) begin errors++; $display("FAIL zero_spm_x got %h exp 12345678", spm_x); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [2*SIZE-1:0] yb, exp_p;
    logic [SIZE-1:0] av, bv;
    for (int i = 0; i < 20; i++) begin
      av = $urandom & 32'h7FFF_FFFF;
      bv = $urandom & 32'h7FFF_FFFF;
      exp_p = 64'(av) * 64'(bv);
      run_op(av, bv, lat, yb);
      checks++; if (lat !== 65) begin errors++; $display("FAIL b2b_latency[%0d] got %0d exp 65", i, lat); end
      checks++; if (product !== exp_p) begin errors++; $display("FAIL b2b_product[%0d] got %h exp %h", i, product, exp_p); end
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    int extra;
    a = 7; b = 9; start = 1;
    tick();
    start = 0;
    lat = 0;
    while (!done && lat < 200) begin
      if (lat == 10) begin a = 1; b = 1; start = 1; end
      else start = 0;
      tick();
      lat++;
    end
    start = 0;
    checks++; if (lat !== 65) begin errors++; $display("FAIL busy_latency got %0d exp 65", lat); end
    checks++; if (product !== 64'h3F) begin errors++; $display("FAIL busy_product got %h exp 3f", product); end
    checks++; if (spm_x !== 32'h7) begin errors++; $display("FAIL busy_spm_x got %h exp 7", spm_x); end
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_second_done got %0d exp 0", extra); end
  endtask

  task automatic test_mid_reset();
    int lat;
    logic [2*SIZE-1:0] yb;
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; start = 1;
    tick();
    start = 0;
    repeat (30) tick();
    rst_n = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mrst_done got %b exp 0", done); end
    checks++; if (product !== 64'h0) begin errors++; $display("FAIL mrst_product got %h exp 0", product); end
    checks++; if (spm_x !== 32'h0) begin errors++; $display("FAIL mrst_spm_x got %h exp 0", spm_x); end
    checks++; if (spm_y !== 1'b0) begin errors++; $display("FAIL mrst_spm_y got %b exp 0", spm_y); end
    checks++; if (spm_rst !== 1'b1) begin errors++; $display("FAIL mrst_spm_rst got %b exp 1", spm_rst); end
    tick();
    rst_n = 1;
    tick();
    run_op(32'd11, 32'd13, lat, yb);
    checks++; if (lat !== 65) begin errors++; $display("FAIL mrst_latency got %0d exp 65", lat); end
    checks++; if (product !== 64'd143) begin errors++; $display("FAIL mrst_product got %h exp 8f", product); end
    tick();
  endtask

`ifdef SPM_BACKPRESSURE_EN
  task automatic test_backpressure();
    int lat;
    logic [2*SIZE-1:0] yb;
    result_ready = 0;
    run_op(32'd100, 32'd200, lat, yb);
    checks++; if (lat !== 65) begin errors++; $display("FAIL bp_latency got %0d exp 65", lat); end
    for (int i = 0; i < 10; i++) begin
      a = 1; b = 1; start = 1;
      tick();
      checks++; if (done !== 1'b1 || product !== 64'd20000) begin errors++; $display("FAIL bp_hold[%0d] got done=%b product=%h exp done=1 product=4e20", i, done, product); end
    end
    result_ready = 1;
    tick();
    start = 0;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got done=%b busy=%b exp 0 0", done, busy); end
    checks++; if (product !== 64'd20000 || spm_x !== 32'd100) begin errors++; $display("FAIL bp_start_ignored got product=%h x=%h exp 4e20 64", product, spm_x); end
    tick();
  endtask
`endif

  initial begin
    #12;
    test_reset();
    rst_n = 1;
    tick();
    test_basic();
    test_full_range();
    test_zero();
    test_back_to_back();
    test_start_while_busy();
    test_mid_reset();
`ifdef SPM_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
